alu_seq: RTL
============

Name: alu_seq

Overview:
- Multi-cycle sequencer in front of the shared 8-bit ALU.
- Accepts one arithmetic/logic command per handshake and drives the ALU controls (op, mem_bi, inv_bi, CI, AI, MI) over one or two cycles.
- For ADC/SBC with decimal mode set, runs a second pass that applies the BCD correction (0x06/0x60/0x66 add, or 0xFA/0xA0/0x9A subtract).
- Returns result, N/Z/C/V and per-flag write enables to the CPU core.

Parameters:
- DEC_SUPPORT, 1, 1 = decimal correction pass enabled; 0 = dec input ignored, all commands binary.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req  in  1  command request
- ready  out  1  high only in IDLE; req is accepted when req & ready at the rising edge of clk
- cmd  in  3  0 ADC, 1 SBC, 2 CMP, 3 AND, 4 ORA, 5 EOR, 6 ASL, 7 LSR
- dec  in  1  decimal mode flag
- c_in  in  1  carry flag in
- a  in  8  accumulator/register operand
- m  in  8  memory operand
- alu_ai, alu_mi  out  8  ALU operands
- alu_ci, alu_mem_bi, alu_inv_bi  out  1  ALU controls
- alu_op  out  3  ALU op code (ALU_* encodings from states.i)
- alu_out  in  8  ALU result
- alu_c, alu_n, alu_z, alu_v, alu_hcb, alu_dhc, alu_dc  in  1  ALU flags
- done  out  1  one-cycle pulse; result and flags valid
- result  out  8  final result
- n, z, c, v  out  1  final flags
- we_res, we_nz, we_c, we_v  out  1  write enables, valid with done

Behaviour:
- Reset: clk is the single clock; rst_n is an asynchronous, active-low reset. On reset: state = IDLE, ready = 1, done = 0, result = 0x00, all flags and write enables = 0, ALU controls = 0. Reset asserted mid-operation aborts the command; no done is produced.
- States: IDLE, BIN, ADJ.
- IDLE: on req & ready, latch cmd, dec, c_in, a and m, then go to BIN. req with ready = 0 is ignored and is not queued.
- BIN: alu_ai = a, alu_mi = m, alu_mem_bi = 1. Per command:
  - ADC: op ALU_ADC, inv 0, ci c_in.
  - SBC: op ALU_ADC, inv 1, ci c_in.
  - CMP: op ALU_ADC, inv 1, ci forced 1.
  - AND/ORA/EOR: matching op, inv 0.
  - ASL: op ALU_ROL, ci 0.
  - LSR: op ALU_ROR, ci 0.
- End of BIN: register alu_out, alu_c, alu_v, alu_hcb, alu_dhc and alu_dc.
- BIN exit: if DEC_SUPPORT & dec & cmd is ADC or SBC, go to ADJ; otherwise go to IDLE with done = 1.
- ADJ correction terms:
  - ADC: lo = hcb | dhc; hi = c_bin | dc. Constant = {hi?6:0, lo?6:0}.
  - SBC: lo = hcb (half borrow); hi = ~c_bin. Constant = hi&lo 0x9A, hi only 0xA0, lo only 0xFA, neither 0x00.
- ADJ drive: alu_ai = binary result, alu_mi = constant, op ALU_ADC, mem 1, inv 0, ci 0. Register the adjusted result, then go to IDLE with done = 1.
- Final flags:
  - C: ADC decimal = c_bin | dc; SBC decimal = c_bin; otherwise alu_c of BIN.
  - V: always from BIN.
  - N/Z: see Optional Feature.
- Write enables:
  - we_res: 1 except CMP.
  - we_nz: 1 for all commands.
  - we_c: ADC, SBC, CMP, ASL, LSR.
  - we_v: ADC, SBC.
- Latency: binary command, done is high in the 2nd cycle after the accept edge (1 compute cycle); decimal command, 3rd cycle.
- Handshake timing: ready returns high in the same cycle as done, so back-to-back requests are accepted at the edge ending the done cycle. done never lasts more than 1 cycle.
- Hold: outputs hold their values until the next done or reset. ALU controls are 0 in IDLE.

Optional Feature:
- Macro: ALU_SEQ_DEC_NZ_EN.
- Defined: in decimal ADC/SBC, N and Z are taken from the corrected (ADJ) result (65C02 behaviour).
- Undefined: N and Z are always taken from the BIN-pass result (NMOS behaviour).
- Non-decimal commands are identical in both builds.

Test Plan:
- ADC binary, a=0x50, m=0x50, c_in=0, dec=0 -> done 1 cycle after accept; result 0xA0, N=1, V=1, C=0, Z=0; we_v=1.
- ADC decimal, 0x19+0x28, c_in=0 -> binary pass 0x41 with hcb=1, correction 0x06; result 0x47, C=0; done 2 cycles after accept.
- ADC decimal, 0x99+0x01, c_in=0 -> binary pass 0x9A, dhc=1, dc=1; result 0x00, C=1. Z=1 with ALU_SEQ_DEC_NZ_EN defined; Z=0, N=1 without.
- SBC decimal, 0x40-0x13, c_in=1 -> binary pass 0x2D, half borrow; result 0x27, C=1.
- CMP, a=0x10, m=0x20 -> C=0, N=1, Z=0, we_res=0, we_v=0. A req held high during BIN is not accepted early.
- Decimal ADC with rst_n pulsed low during ADJ -> ready=1, done never pulses, result=0x00; a following ADC 0x01+0x01 completes normally with result 0x02.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: multi-cycle command sequencer in front of the shared 8-bit ALU.
//
// One arithmetic/logic command is accepted per handshake. The sequencer
// drives the ALU controls for one binary pass (BIN) and, for decimal-mode
// ADC/SBC, a second pass (ADJ) that adds the BCD correction constant.
// It then returns the result, N/Z/C/V and the per-flag write enables.
//
// Handshake: a command is accepted on a rising clk edge where req & ready.
// ready is high only in IDLE. done is a single-cycle pulse marking result,
// flags and write enables valid. These outputs then hold until the next
// done or reset. ready is already high in the done cycle, so a new command
// can be accepted at the edge that ends it.
//
// Parameter:
//   DEC_SUPPORT  1 = decimal correction pass enabled, 0 = dec input ignored
//
// Build option:
//   ALU_SEQ_DEC_NZ_EN  defined   -> decimal ADC/SBC take N/Z from the
//                                   corrected result (65C02 behaviour)
//                      undefined -> N/Z always come from the binary pass
//                                   (NMOS behaviour)
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req, ready                  command handshake
//   cmd[2:0]                    0 ADC,1 SBC,2 CMP,3 AND,4 ORA,5 EOR,6 ASL,7 LSR
//   dec, c_in, a[7:0], m[7:0]   command operands, latched on accept
//   alu_ai, alu_mi, alu_ci,
//   alu_mem_bi, alu_inv_bi,
//   alu_op[2:0]                 ALU controls (all zero in IDLE)
//   alu_out, alu_c, alu_n,
//   alu_z, alu_v, alu_hcb,
//   alu_dhc, alu_dc             ALU result and flags
//   done, result, n, z, c, v    completion pulse, final result and flags
//   we_res, we_nz, we_c, we_v   write enables, valid with done
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter bit DEC_SUPPORT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       ready,
  input  logic [2:0] cmd,
  input  logic       dec,
  input  logic       c_in,
  input  logic [7:0] a,
  input  logic [7:0] m,
  output logic [7:0] alu_ai,
  output logic [7:0] alu_mi,
  output logic       alu_ci,
  output logic       alu_mem_bi,
  output logic       alu_inv_bi,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_hcb,
  input  logic       alu_dhc,
  input  logic       alu_dc,
  output logic       done,
  output logic [7:0] result,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v,
  output logic       we_res,
  output logic       we_nz,
  output logic       we_c,
  output logic       we_v
);

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BIN  = 2'd1;
  localparam logic [1:0] S_ADJ  = 2'd2;

  // ALU op encodings shared with the ALU
  localparam logic [2:0] ALU_ADC = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_ORA = 3'd2;
  localparam logic [2:0] ALU_EOR = 3'd3;
  localparam logic [2:0] ALU_ROL = 3'd4;
  localparam logic [2:0] ALU_ROR = 3'd5;

  // Command encodings
  localparam logic [2:0] CMD_ADC = 3'd0;
  localparam logic [2:0] CMD_SBC = 3'd1;
  localparam logic [2:0] CMD_CMP = 3'd2;
  localparam logic [2:0] CMD_AND = 3'd3;
  localparam logic [2:0] CMD_ORA = 3'd4;
  localparam logic [2:0] CMD_EOR = 3'd5;
  localparam logic [2:0] CMD_ASL = 3'd6;
  localparam logic [2:0] CMD_LSR = 3'd7;

  logic [1:0] state;

  // Command latched at accept
  logic [2:0] cmd_q;
  logic       dec_q;
  logic       ci_q;
  logic [7:0] a_q;
  logic [7:0] m_q;

  // Binary-pass results, kept for the correction pass and final flags
  logic [7:0] bin_res;
  logic       bin_c;
  logic       bin_v;
  logic       bin_n;
  logic       bin_z;
  logic       bin_hcb;
  logic       bin_dhc;
  logic       bin_dc;

  logic       is_addsub;
  logic       go_dec;
  logic       adj_lo;
  logic       adj_hi;
  logic [7:0] adj_const;
  logic       we_res_nxt;
  logic       we_c_nxt;
  logic       we_v_nxt;

  assign ready     = (state == S_IDLE);
  assign is_addsub = (cmd_q == CMD_ADC) || (cmd_q == CMD_SBC);
  assign go_dec    = DEC_SUPPORT && dec_q && is_addsub;

  // Write enables depend only on the latched command
  assign we_res_nxt = (cmd_q != CMD_CMP);
  assign we_c_nxt   = (cmd_q == CMD_ADC) || (cmd_q == CMD_SBC) ||
                      (cmd_q == CMD_CMP) || (cmd_q == CMD_ASL) ||
                      (cmd_q == CMD_LSR);
  assign we_v_nxt   = is_addsub;

  // BCD correction constant. For SBC the operand was inverted, so
  // hcb reads as half borrow and a clear carry means full borrow; the
  // subtract constants are the two's complement of 0x06/0x60/0x66.
  always_comb begin
    adj_lo    = 1'b0;
    adj_hi    = 1'b0;
    adj_const = 8'h00;
    if (cmd_q == CMD_SBC) begin
      adj_lo = bin_hcb;
      adj_hi = ~bin_c;
      case ({adj_hi, adj_lo})
        2'b11:   adj_const = 8'h9A;
        2'b10:   adj_const = 8'hA0;
        2'b01:   adj_const = 8'hFA;
        default: adj_const = 8'h00;
      endcase
    end else begin
      adj_lo    = bin_hcb | bin_dhc;
      adj_hi    = bin_c | bin_dc;
      adj_const = {(adj_hi ? 4'h6 : 4'h0), (adj_lo ? 4'h6 : 4'h0)};
    end
  end

  // ALU control drive; everything stays zero in IDLE
  always_comb begin
    alu_ai     = 8'h00;
    alu_mi     = 8'h00;
    alu_ci     = 1'b0;
    alu_mem_bi = 1'b0;
    alu_inv_bi = 1'b0;
    alu_op     = 3'b000;
    case (state)
      S_BIN: begin
        alu_ai     = a_q;
        alu_mi     = m_q;
        alu_mem_bi = 1'b1;
        case (cmd_q)
          CMD_ADC: begin alu_op = ALU_ADC; alu_ci = ci_q; end
          CMD_SBC: begin alu_op = ALU_ADC; alu_inv_bi = 1'b1; alu_ci = ci_q; end
          CMD_CMP: begin alu_op = ALU_ADC; alu_inv_bi = 1'b1; alu_ci = 1'b1; end
          CMD_AND: alu_op = ALU_AND;
          CMD_ORA: alu_op = ALU_ORA;
          CMD_EOR: alu_op = ALU_EOR;
          CMD_ASL: alu_op = ALU_ROL;
          default: alu_op = ALU_ROR;
        endcase
      end
      S_ADJ: begin
        alu_ai     = bin_res;
        alu_mi     = adj_const;
        alu_op     = ALU_ADC;
        alu_mem_bi = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cmd_q   <= 3'd0;
      dec_q   <= 1'b0;
      ci_q    <= 1'b0;
      a_q     <= 8'h00;
      m_q     <= 8'h00;
      bin_res <= 8'h00;
      bin_c   <= 1'b0;
      bin_v   <= 1'b0;
      bin_n   <= 1'b0;
      bin_z   <= 1'b0;
      bin_hcb <= 1'b0;
      bin_dhc <= 1'b0;
      bin_dc  <= 1'b0;
      done    <= 1'b0;
      result  <= 8'h00;
      n       <= 1'b0;
      z       <= 1'b0;
      c       <= 1'b0;
      v       <= 1'b0;
      we_res  <= 1'b0;
      we_nz   <= 1'b0;
      we_c    <= 1'b0;
      we_v    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cmd_q <= cmd;
            dec_q <= dec;
            ci_q  <= c_in;
            a_q   <= a;
            m_q   <= m;
            state <= S_BIN;
          end
        end
        S_BIN: begin
          bin_res <= alu_out;
          bin_c   <= alu_c;
          bin_v   <= alu_v;
          bin_n   <= alu_n;
          bin_z   <= alu_z;
          bin_hcb <= alu_hcb;
          bin_dhc <= alu_dhc;
          bin_dc  <= alu_dc;
          if (go_dec) begin
            state <= S_ADJ;
          end else begin
            state  <= S_IDLE;
            done   <= 1'b1;
            result <= alu_out;
            n      <= alu_n;
            z      <= alu_z;
            c      <= alu_c;
            v      <= alu_v;
            we_res <= we_res_nxt;
            we_nz  <= 1'b1;
            we_c   <= we_c_nxt;
            we_v   <= we_v_nxt;
          end
        end
        S_ADJ: begin
          state  <= S_IDLE;
          done   <= 1'b1;
          result <= alu_out;
          // Decimal carry: ADC carries on binary carry or decimal carry;
          // SBC keeps the binary borrow.
          c      <= (cmd_q == CMD_ADC) ? (bin_c | bin_dc) : bin_c;
          v      <= bin_v;
`ifdef ALU_SEQ_DEC_NZ_EN
          n      <= alu_n;
          z      <= alu_z;
`else
          n      <= bin_n;
          z      <= bin_z;
`endif
          we_res <= we_res_nxt;
          we_nz  <= 1'b1;
          we_c   <= we_c_nxt;
          we_v   <= we_v_nxt;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
